// File: rtl/corefifo_wptr_gray_gen_vdma_if.sv
// Write-side bus of the VDMA async FIFO pointer generator: upstream request,
// synchronised read pointer in, RAM write controls and status flags out.
interface corefifo_wptr_gray_gen_vdma_if #(
  parameter int unsigned ADDRWIDTH = 3
);
  localparam int unsigned PW = ADDRWIDTH + 1;

  logic                 wr_en;
  logic [PW-1:0]        rgray_sync;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] waddr;
  logic [PW-1:0]        wptr_gray;
  logic                 full;
  logic                 afull;
  logic [PW-1:0]        wr_count;
  logic                 overflow;

  // Upstream writer / read-pointer synchroniser side
  modport master (
    output wr_en, rgray_sync,
    input  mem_we, waddr, wptr_gray, full, afull, wr_count, overflow
  );

  // Pointer generator side
  modport slave (
    input  wr_en, rgray_sync,
    output mem_we, waddr, wptr_gray, full, afull, wr_count, overflow
  );
endinterface

// File: rtl/corefifo_wptr_gray_gen_vdma.sv
// Write-clock-domain pointer/flag generator for the VDMA async FIFO: binary
// write address, registered Gray write pointer, full/afull/occupancy/overflow.
module corefifo_wptr_gray_gen_vdma #(
  parameter int unsigned ADDRWIDTH    = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  corefifo_wptr_gray_gen_vdma_if.slave  bus
);
  localparam int unsigned PW    = ADDRWIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDRWIDTH;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] count_next;
  logic [PW-1:0] wptr_gray_q;
  logic [PW-1:0] wr_count_q;
  logic          full_q;
  logic          afull_q;
  logic          overflow_q;
  logic          accept;

  // Write acceptance only depends on the registered full flag
  always_comb begin
    accept    = bus.wr_en & ~full_q;
    wbin_next = wbin + PW'(accept);
  end

  // Gray-to-binary of the synchronised read pointer: bit i = XOR of bits PW-1..i
  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin[i] = ^(bus.rgray_sync >> i);
    end
  end

  // Occupancy is relative to a late read pointer, so it can only overstate
  always_comb begin
    count_next = wbin_next - rbin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin        <= '0;
      wptr_gray_q <= '0;
      wr_count_q  <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray_q <= wbin_next ^ (wbin_next >> 1);
      wr_count_q  <= count_next;
      full_q      <= (count_next == PW'(DEPTH));
      afull_q     <= (count_next >= PW'(AFULL_THRESH));
      overflow_q  <= bus.wr_en & full_q;
    end
  end

  // RAM enable is held low for the whole reset period regardless of wr_en
  assign bus.mem_we    = accept & ~rst;
  assign bus.waddr     = wbin[ADDRWIDTH-1:0];
  assign bus.wptr_gray = wptr_gray_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.full      = full_q;
  assign bus.afull     = afull_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/corefifo_wptr_gray_gen_vdma.md
Name: corefifo_wptr_gray_gen_vdma

Overview:
Write-side pointer and flag generator for the VDMA asynchronous FIFO; it produces the Gray-coded write pointer that the destination-domain N-stage synchroniser samples. It maintains the binary write address for the RAM, gates writes against full, and derives full, almost-full and occupancy from the read Gray pointer already synchronised into this clock domain. Instantiated once per FIFO on the write-clock side.

Parameters:
ADDRWIDTH, 3, RAM address width; FIFO depth DEPTH = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits; legal range 2..12.
AFULL_THRESH, 6, occupancy at or above which afull asserts; legal range 1..DEPTH.

Ports:
clk  input  1  write-domain clock, rising edge.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  write request from upstream.
rgray_sync  input  ADDRWIDTH+1  read Gray pointer, already synchronised to clk.
mem_we  output  1  RAM write enable = wr_en & ~full (combinational from registered full).
waddr  output  ADDRWIDTH  RAM write address = wbin[ADDRWIDTH-1:0].
wptr_gray  output  ADDRWIDTH+1  registered Gray write pointer to the crossing synchroniser.
full  output  1  registered; FIFO holds DEPTH entries.
afull  output  1  registered; wr_count >= AFULL_THRESH.
wr_count  output  ADDRWIDTH+1  registered occupancy seen from the write side, 0..DEPTH.
overflow  output  1  registered one-cycle pulse: write requested while full.

Behaviour:
- Reset (rst high, asynchronous, immediate): wbin=0, wptr_gray=0, waddr=0, full=0, afull=0, wr_count=0, overflow=0; mem_we=0 for the whole reset period regardless of wr_en.
- accept = wr_en & ~full. wbin_next = wbin + accept, modulo 2^(ADDRWIDTH+1) (natural wrap, no saturation).
- Every edge: wbin <= wbin_next; wptr_gray <= wbin_next ^ (wbin_next >> 1). wptr_gray must come straight from a flop; no combinational logic between flop and port.
- rbin = Gray-to-binary of rgray_sync (bit i = XOR of bits ADDRWIDTH..i), combinational.
- count_next = (wbin_next - rbin) modulo 2^(ADDRWIDTH+1). Registered: wr_count <= count_next; full <= (count_next == DEPTH); afull <= (count_next >= AFULL_THRESH).
- Latency: accepted write in cycle n -> waddr, wptr_gray, wr_count, full, afull updated at the edge ending cycle n (visible in n+1). No combinational wr_en->full path.
- overflow <= wr_en & full; pointers and count unchanged on a rejected write.
- Exactly one bit of wptr_gray changes per accepted write, including the wrap 2^(ADDRWIDTH+1)-1 -> 0; no change when accept=0.
- rgray_sync advancing while full: full deasserts at the next edge, so the first accept is possible one cycle after the change.
- Simultaneous accepted write and rgray_sync advance: count unchanged.
- Count is pessimistic (read pointer is late), never optimistic; rgray_sync is assumed Gray-legal, with no multi-bit-change detection.
- Reset mid-burst: state cleared instantly; the first write after release goes to waddr 0.

Test Plan:
- Reset: rst=1, wr_en=1 -> mem_we=0, wptr_gray=0000, waddr=0, full=0, wr_count=0; after release, first write at waddr=0.
- Fill (ADDRWIDTH=3, rgray_sync=0000), 8 back-to-back writes -> wptr_gray 0001,0011,0010,0110,0111,0101,0100,1100; afull after the 6th write, full after the 8th; 9th write: mem_we=0, overflow=1 for one cycle, wptr_gray stays 1100.
- From full, rgray_sync 0000->0001 -> next cycle full=0, wr_count=7; write accepted at waddr=0, full=1 again.
- Wrap: 16 writes with rgray_sync tracking wptr_gray -> waddr 7->0 twice, wptr_gray 1000->0000 at the wrap, single-bit change every step, full never set.
- At wr_count=7, write plus rgray_sync advance in the same cycle -> wr_count stays 7, full=0, afull=1.
- Reset asserted after 5 writes with wr_en held -> outputs 0 immediately (not at the clock edge); after release, writes restart at waddr 0 and wptr_gray 0001.
